// File: rtl/ccip_limiter_pkg.sv
// Purpose : shared CCI-P request/response types and helpers for the outstanding-line limiter.
// Latency : n/a (types and pure functions only).
// Backpr. : n/a. t_line_cnt matches the limiter's default counter width.
package ccip_limiter_pkg;

    localparam int LIMITER_CNT_W = 10;
    typedef logic [LIMITER_CNT_W-1:0] t_line_cnt;

    // Request type encodings
    localparam logic [3:0] eREQ_RDLINE_I = 4'h0;
    localparam logic [3:0] eREQ_RDLINE_S = 4'h1;
    localparam logic [3:0] eREQ_WRLINE_I = 4'h0;
    localparam logic [3:0] eREQ_WRLINE_M = 4'h1;
    localparam logic [3:0] eREQ_WRPUSH_I = 4'h2;
    localparam logic [3:0] eREQ_WRFENCE  = 4'h4;
    localparam logic [3:0] eREQ_INTR     = 4'h6;

    // Response type encodings
    localparam logic [3:0] eRSP_RDLINE   = 4'h0;
    localparam logic [3:0] eRSP_WRLINE   = 4'h1;
    localparam logic [3:0] eRSP_WRFENCE  = 4'h4;
    localparam logic [3:0] eRSP_INTR     = 4'h6;

    typedef struct packed {
        logic [1:0]  vc_sel;
        logic [1:0]  rsvd1;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [5:0]  rsvd0;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [5:0]  rsvd2;
        logic [1:0]  vc_sel;
        logic        sop;
        logic        rsvd1;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [5:0]  rsvd0;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic [1:0]  rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic        format;
        logic        rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        logic [511:0]       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    // Lines carried by a multi-line read; the reserved encoding counts as one line.
    function automatic logic [2:0] cl_len_lines(input logic [1:0] cl_len);
        case (cl_len)
            2'b01:   return 3'd2;
            2'b11:   return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic is_rd_req(input logic [3:0] req_type);
        return (req_type == eREQ_RDLINE_I) || (req_type == eREQ_RDLINE_S);
    endfunction

    // Fences and interrupts carry no line and are deliberately excluded.
    function automatic logic is_wr_req(input logic [3:0] req_type);
        return (req_type == eREQ_WRLINE_I) || (req_type == eREQ_WRLINE_M) ||
               (req_type == eREQ_WRPUSH_I);
    endfunction

endpackage

// File: rtl/ccip_line_counter.sv
// Purpose : saturating up/down line counter with registered threshold and sticky error flags.
//           Ports: clk/rst, inc/dec (lines this cycle), cnt, thr, err_underflow, err_overflow.
// Latency : cnt/thr/flags update on the edge that samples inc/dec; no backpressure (always accepts).
module ccip_line_counter #(
    parameter int MAX   = 256,
    parameter int CNT_W = 10,
    parameter int SLACK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       inc,
    input  logic [2:0]       dec,
    output logic [CNT_W-1:0] cnt,
    output logic             thr,
    output logic             err_underflow,
    output logic             err_overflow
);

    // One extra bit holds cnt+inc without wrapping.
    localparam int EW = CNT_W + 1;
    localparam logic [EW-1:0] CNT_TOP = {1'b0, {CNT_W{1'b1}}};
    localparam logic [EW-1:0] MAX_E   = EW'(MAX);
    localparam logic [EW-1:0] THR_E   = EW'(MAX - SLACK);

    logic [EW-1:0]    up;
    logic [EW-1:0]    diff;
    logic [CNT_W-1:0] cnt_nxt;
    logic             under;
    logic             over;
    logic             thr_nxt;

    // Net update: increment and decrement combine with no priority between them.
    always_comb begin
        up      = {1'b0, cnt} + EW'(inc);
        under   = EW'(dec) > up;
        diff    = under ? '0 : (up - EW'(dec));
        over    = diff > MAX_E;
        thr_nxt = diff >= THR_E;
        cnt_nxt = (diff > CNT_TOP) ? {CNT_W{1'b1}} : diff[CNT_W-1:0];
    end

    // Throttle resets asserted so the AFU stays quiet until counts are known.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            thr           <= 1'b1;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            cnt           <= cnt_nxt;
            thr           <= thr_nxt;
            err_underflow <= err_underflow | under;
            err_overflow  <= err_overflow | over;
        end
    end

endmodule

// File: rtl/ccip_outstanding_limiter.sv
// Purpose : bounds outstanding c0 read / c1 write lines by forcing almFull towards the AFU.
//           Ports: afu_clk, afu_softreset, afu_tx_in/out, afu_rx_in/out, counts, sticky errors.
// Latency : Tx 1 cycle registered, Rx combinational; flow control only via c0/c1 TxAlmFull.
// Optional: CCIP_OUTSTANDING_LIMITER_STATS_EN adds rd_thr_cycles / wr_thr_cycles.
module ccip_outstanding_limiter
    import ccip_limiter_pkg::*;
#(
    parameter int MAX_RD_LINES  = 256,
    parameter int MAX_WR_LINES  = 256,
    parameter int CNT_W         = LIMITER_CNT_W,
    parameter int ALMFULL_SLACK = 8
) (
    input  logic             afu_clk,
    input  logic             afu_softreset,
    input  t_if_ccip_Tx      afu_tx_in,
    output t_if_ccip_Tx      afu_tx_out,
    input  t_if_ccip_Rx      afu_rx_in,
    output t_if_ccip_Rx      afu_rx_out,
    output logic [CNT_W-1:0] rd_outstanding,
    output logic [CNT_W-1:0] wr_outstanding,
    output logic             err_underflow,
    output logic             err_overflow
`ifdef CCIP_OUTSTANDING_LIMITER_STATS_EN
    ,
    output logic [31:0]      rd_thr_cycles,
    output logic [31:0]      wr_thr_cycles
`endif
);

    logic [2:0] rd_inc;
    logic [2:0] rd_dec;
    logic [2:0] wr_inc;
    logic [2:0] wr_dec;
    logic       rd_thr;
    logic       wr_thr;
    logic       rd_uf;
    logic       rd_of;
    logic       wr_uf;
    logic       wr_of;

    always_comb begin
        rd_inc = '0;
        rd_dec = '0;
        wr_inc = '0;
        wr_dec = '0;
        if (afu_tx_in.c0.valid && is_rd_req(afu_tx_in.c0.hdr.req_type))
            rd_inc = cl_len_lines(afu_tx_in.c0.hdr.cl_len);
        if (afu_rx_in.c0.rspValid && (afu_rx_in.c0.hdr.resp_type == eRSP_RDLINE))
            rd_dec = 3'd1;
        if (afu_tx_in.c1.valid && is_wr_req(afu_tx_in.c1.hdr.req_type))
            wr_inc = 3'd1;
        // A packed write response retires cl_num+1 lines at once.
        if (afu_rx_in.c1.rspValid && (afu_rx_in.c1.hdr.resp_type == eRSP_WRLINE))
            wr_dec = afu_rx_in.c1.hdr.format ? ({1'b0, afu_rx_in.c1.hdr.cl_num} + 3'd1) : 3'd1;
    end

    ccip_line_counter #(
        .MAX   (MAX_RD_LINES),
        .CNT_W (CNT_W),
        .SLACK (ALMFULL_SLACK)
    ) u_rd_cnt (
        .clk           (afu_clk),
        .rst           (afu_softreset),
        .inc           (rd_inc),
        .dec           (rd_dec),
        .cnt           (rd_outstanding),
        .thr           (rd_thr),
        .err_underflow (rd_uf),
        .err_overflow  (rd_of)
    );

    ccip_line_counter #(
        .MAX   (MAX_WR_LINES),
        .CNT_W (CNT_W),
        .SLACK (ALMFULL_SLACK)
    ) u_wr_cnt (
        .clk           (afu_clk),
        .rst           (afu_softreset),
        .inc           (wr_inc),
        .dec           (wr_dec),
        .cnt           (wr_outstanding),
        .thr           (wr_thr),
        .err_underflow (wr_uf),
        .err_overflow  (wr_of)
    );

    assign err_underflow = rd_uf | wr_uf;
    assign err_overflow  = rd_of | wr_of;

    // Whole struct is cleared so no stale request is replayed after reset.
    always_ff @(posedge afu_clk or posedge afu_softreset) begin
        if (afu_softreset) afu_tx_out <= '0;
        else               afu_tx_out <= afu_tx_in;
    end

    always_comb begin
        afu_rx_out             = afu_rx_in;
        afu_rx_out.c0TxAlmFull = afu_rx_in.c0TxAlmFull | rd_thr;
        afu_rx_out.c1TxAlmFull = afu_rx_in.c1TxAlmFull | wr_thr;
    end

`ifdef CCIP_OUTSTANDING_LIMITER_STATS_EN
    always_ff @(posedge afu_clk or posedge afu_softreset) begin
        if (afu_softreset) begin
            rd_thr_cycles <= '0;
            wr_thr_cycles <= '0;
        end else begin
            if (rd_thr && !(&rd_thr_cycles)) rd_thr_cycles <= rd_thr_cycles + 32'd1;
            if (wr_thr && !(&wr_thr_cycles)) wr_thr_cycles <= wr_thr_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ccip_outstanding_limiter.sv
// Purpose : self-checking bench for ccip_outstanding_limiter (directed cases plus random traffic).
// Latency : model expects Tx delayed one cycle, Rx same cycle, counts/throttle after each edge.
// Backpr. : none driven; almFull outputs are checked, not obeyed.
module tb_ccip_outstanding_limiter;
    import ccip_limiter_pkg::*;

    localparam int MAXR = 256;
    localparam int MAXW = 256;
    localparam int CW   = 10;
    localparam int SL   = 8;
    localparam int CTOP = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    t_if_ccip_Tx tx_in = '0;
    t_if_ccip_Tx tx_out;
    t_if_ccip_Rx rx_in = '0;
    t_if_ccip_Rx rx_out;
    logic [CW-1:0] rd_o;
    logic [CW-1:0] wr_o;
    logic        eu;
    logic        eo;
`ifdef CCIP_OUTSTANDING_LIMITER_STATS_EN
    logic [31:0] rd_tc;
    logic [31:0] wr_tc;
`endif

    ccip_outstanding_limiter #(
        .MAX_RD_LINES  (MAXR),
        .MAX_WR_LINES  (MAXW),
        .CNT_W         (CW),
        .ALMFULL_SLACK (SL)
    ) dut (
        .afu_clk        (clk),
        .afu_softreset  (rst),
        .afu_tx_in      (tx_in),
        .afu_tx_out     (tx_out),
        .afu_rx_in      (rx_in),
        .afu_rx_out     (rx_out),
        .rd_outstanding (rd_o),
        .wr_outstanding (wr_o),
        .err_underflow  (eu),
        .err_overflow   (eo)
`ifdef CCIP_OUTSTANDING_LIMITER_STATS_EN
        ,
        .rd_thr_cycles  (rd_tc),
        .wr_thr_cycles  (wr_tc)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    int          m_rd, m_wr;
    bit          m_rthr, m_wthr, m_eu, m_eo;
    t_if_ccip_Tx m_tx;
    int          len_lines [4] = '{1, 2, 1, 4};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rd_lines(input t_if_ccip_Tx t);
        if (t.c0.valid && (t.c0.hdr.req_type inside {eREQ_RDLINE_I, eREQ_RDLINE_S}))
            return len_lines[t.c0.hdr.cl_len];
        return 0;
    endfunction

    function automatic int wr_lines(input t_if_ccip_Tx t);
        if (t.c1.valid && (t.c1.hdr.req_type inside {eREQ_WRLINE_I, eREQ_WRLINE_M, eREQ_WRPUSH_I}))
            return 1;
        return 0;
    endfunction

    function automatic int rd_rsp(input t_if_ccip_Rx r);
        return (r.c0.rspValid && r.c0.hdr.resp_type == eRSP_RDLINE) ? 1 : 0;
    endfunction

    function automatic int wr_rsp(input t_if_ccip_Rx r);
        if (r.c1.rspValid && r.c1.hdr.resp_type == eRSP_WRLINE)
            return r.c1.hdr.format ? (int'(r.c1.hdr.cl_num) + 1) : 1;
        return 0;
    endfunction

    // Outstanding lines = issued - retired, floored at zero, capped at counter range.
    task automatic model_count(inout int c, input int add, input int sub, input int mx,
                               inout bit thr, inout bit uf, inout bit of);
        int n;
        n = c + add - sub;
        if (n < 0) begin
            uf = 1'b1;
            n  = 0;
        end
        if (n > mx) of = 1'b1;
        thr = (n >= mx - SL);
        c   = (n > CTOP) ? CTOP : n;
    endtask

    // Model advances on each edge, DUT is compared 1 time unit later.
    always begin
        t_if_ccip_Rx exp_rx;
        @(posedge clk);
        if (rst) begin
            m_rd = 0; m_wr = 0; m_rthr = 1'b1; m_wthr = 1'b1;
            m_eu = 1'b0; m_eo = 1'b0; m_tx = '0;
        end else begin
            model_count(m_rd, rd_lines(tx_in), rd_rsp(rx_in), MAXR, m_rthr, m_eu, m_eo);
            model_count(m_wr, wr_lines(tx_in), wr_rsp(rx_in), MAXW, m_wthr, m_eu, m_eo);
            m_tx = tx_in;
        end
        #1;
        chk("rd_outstanding", 64'(rd_o), 64'(m_rd));
        chk("wr_outstanding", 64'(wr_o), 64'(m_wr));
        chk("err_underflow", 64'(eu), 64'(m_eu));
        chk("err_overflow", 64'(eo), 64'(m_eo));
        n_chk++;
        if (tx_out !== m_tx) begin
            n_fail++;
            $display("FAIL tx_delay: got valids c0=%b c1=%b c2=%b addr0=%h, expected c0=%b c1=%b c2=%b addr0=%h",
                     tx_out.c0.valid, tx_out.c1.valid, tx_out.c2.mmioRdValid, tx_out.c0.hdr.address,
                     m_tx.c0.valid, m_tx.c1.valid, m_tx.c2.mmioRdValid, m_tx.c0.hdr.address);
        end
        exp_rx = rx_in;
        exp_rx.c0TxAlmFull = rx_in.c0TxAlmFull | m_rthr;
        exp_rx.c1TxAlmFull = rx_in.c1TxAlmFull | m_wthr;
        n_chk++;
        if (rx_out !== exp_rx) begin
            n_fail++;
            $display("FAIL rx_pass: got almfull=%b%b rsp=%b%b mdata0=%h, expected almfull=%b%b rsp=%b%b mdata0=%h",
                     rx_out.c0TxAlmFull, rx_out.c1TxAlmFull, rx_out.c0.rspValid, rx_out.c1.rspValid,
                     rx_out.c0.hdr.mdata, exp_rx.c0TxAlmFull, exp_rx.c1TxAlmFull,
                     exp_rx.c0.rspValid, exp_rx.c1.rspValid, exp_rx.c0.hdr.mdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic t_if_ccip_Tx rand_tx();
        logic [$bits(t_if_ccip_Tx)-1:0] v;
        logic [3:0] rt [4] = '{eREQ_RDLINE_I, eREQ_RDLINE_S, 4'h8, eREQ_RDLINE_I};
        logic [3:0] wt [5] = '{eREQ_WRLINE_I, eREQ_WRLINE_M, eREQ_WRPUSH_I, eREQ_WRFENCE, eREQ_INTR};
        logic [1:0] cl [3] = '{2'b00, 2'b01, 2'b11};
        t_if_ccip_Tx t;
        for (int i = 0; i < $bits(v); i++) v[i] = 1'($urandom);
        t = t_if_ccip_Tx'(v);
        t.c0.valid          = ($urandom_range(0, 2) == 0);
        t.c0.hdr.req_type   = rt[$urandom_range(0, 3)];
        t.c0.hdr.cl_len     = cl[$urandom_range(0, 2)];
        t.c1.valid          = ($urandom_range(0, 2) == 0);
        t.c1.hdr.req_type   = wt[$urandom_range(0, 4)];
        return t;
    endfunction

    function automatic t_if_ccip_Rx rand_rx(input int rsp_pct);
        logic [$bits(t_if_ccip_Rx)-1:0] v;
        logic [3:0] r0 [3] = '{eRSP_RDLINE, eRSP_RDLINE, eRSP_WRLINE};
        logic [3:0] r1 [3] = '{eRSP_WRLINE, eRSP_WRFENCE, eRSP_INTR};
        t_if_ccip_Rx r;
        for (int i = 0; i < $bits(v); i++) v[i] = 1'($urandom);
        r = t_if_ccip_Rx'(v);
        r.c0.rspValid      = ($urandom_range(0, 99) < rsp_pct);
        r.c0.hdr.resp_type = r0[$urandom_range(0, 2)];
        r.c1.rspValid      = ($urandom_range(0, 99) < rsp_pct);
        r.c1.hdr.resp_type = r1[$urandom_range(0, 2)];
        return r;
    endfunction

    task automatic do_reset();
        tx_in = '0;
        rx_in = '0;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        tick();
    endtask

    task automatic rd_req(input logic [1:0] cl_len);
        tx_in = '0;
        tx_in.c0.valid        = 1'b1;
        tx_in.c0.hdr.req_type = eREQ_RDLINE_I;
        tx_in.c0.hdr.cl_len   = cl_len;
    endtask

    initial begin
        // Reset with requests valid on every channel.
        tx_in = rand_tx();
        tx_in.c0.valid = 1'b1;
        tx_in.c1.valid = 1'b1;
        tx_in.c2.mmioRdValid = 1'b1;
        repeat (2) tick();
        chk("rst_c0_almfull", 64'(rx_out.c0TxAlmFull), 64'd1);
        chk("rst_c1_almfull", 64'(rx_out.c1TxAlmFull), 64'd1);
        chk("rst_tx_valid", 64'({tx_out.c0.valid, tx_out.c1.valid, tx_out.c2.mmioRdValid}), 64'd0);
        chk("rst_rd_cnt", 64'(rd_o), 64'd0);
        tx_in = '0;
        rst   = 1'b0;
        tick();
        chk("post_rst_c0_almfull", 64'(rx_out.c0TxAlmFull), 64'd0);
        chk("post_rst_c1_almfull", 64'(rx_out.c1TxAlmFull), 64'd0);

        // Read-count climb to the almFull threshold, overflow and saturation.
        for (int i = 0; i < 62; i++) begin rd_req(2'b00); tick(); end
        tx_in = '0;
        chk("rd_62", 64'(rd_o), 64'd62);
        chk("rd_62_almfull", 64'(rx_out.c0TxAlmFull), 64'd0);
        for (int i = 0; i < 91; i++) begin rd_req(2'b01); tick(); end
        tx_in = '0;
        chk("rd_244", 64'(rd_o), 64'd244);
        chk("rd_244_almfull", 64'(rx_out.c0TxAlmFull), 64'd0);
        rd_req(2'b11); tick(); tx_in = '0;
        chk("rd_248", 64'(rd_o), 64'd248);
        chk("rd_248_almfull", 64'(rx_out.c0TxAlmFull), 64'd1);
        chk("rd_248_no_overflow", 64'(eo), 64'd0);
        for (int i = 0; i < 3; i++) begin rd_req(2'b11); tick(); end
        tx_in = '0;
        chk("rd_260", 64'(rd_o), 64'd260);
        chk("rd_260_overflow", 64'(eo), 64'd1);
        for (int i = 0; i < 200; i++) begin rd_req(2'b11); tick(); end
        tx_in = '0;
        chk("rd_saturate", 64'(rd_o), 64'd1023);
        do_reset();
        chk("overflow_cleared", 64'(eo), 64'd0);

        // Simultaneous 4-line read and one read response from count 10.
        for (int i = 0; i < 10; i++) begin rd_req(2'b00); tick(); end
        rd_req(2'b11);
        rx_in = '0;
        rx_in.c0.rspValid      = 1'b1;
        rx_in.c0.hdr.resp_type = eRSP_RDLINE;
        tick();
        tx_in = '0; rx_in = '0;
        chk("rd_net_13", 64'(rd_o), 64'd13);

        // Four write beats retired by one packed response.
        for (int i = 0; i < 4; i++) begin
            tx_in = '0;
            tx_in.c1.valid        = 1'b1;
            tx_in.c1.hdr.req_type = eREQ_WRLINE_I;
            tick();
        end
        tx_in = '0;
        chk("wr_4", 64'(wr_o), 64'd4);
        rx_in.c1.rspValid      = 1'b1;
        rx_in.c1.hdr.resp_type = eRSP_WRLINE;
        rx_in.c1.hdr.format    = 1'b1;
        rx_in.c1.hdr.cl_num    = 2'd3;
        tick();
        rx_in = '0;
        chk("wr_packed_0", 64'(wr_o), 64'd0);
        chk("wr_packed_no_uf", 64'(eu), 64'd0);

        // Read response with nothing outstanding.
        do_reset();
        rx_in.c0.rspValid      = 1'b1;
        rx_in.c0.hdr.resp_type = eRSP_RDLINE;
        tick();
        rx_in = '0;
        chk("uf_cnt_0", 64'(rd_o), 64'd0);
        chk("uf_set", 64'(eu), 64'd1);
        repeat (5) tick();
        chk("uf_sticky", 64'(eu), 64'd1);
        do_reset();
        chk("uf_cleared", 64'(eu), 64'd0);

        // Random traffic, a mid-traffic reset, then response-heavy traffic.
        for (int i = 0; i < 600; i++) begin
            tx_in = rand_tx();
            rx_in = rand_rx(15);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tx_in = rand_tx();
            rx_in = rand_rx(40);
            tick();
        end
        tx_in = '0;
        rx_in = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
